// File: rtl/busca_aproximacao.sv
// busca_aproximacao: successive-approximation search engine.
// Drives a trial value onto the comparator's b input and refines it MSB-first
// from the M (target > guess) and I (target == guess) flags until the hidden
// target is resolved. Exact equality ends the search early.
module busca_aproximacao #(
    parameter int WIDTH = 8,
    parameter int SW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             M,
    input  logic             I,
    output logic [WIDTH-1:0] guess,
    output logic [WIDTH-1:0] result,
    output logic [SW-1:0]    steps,
    output logic             busy,
    output logic             done
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0]    IDX_TOP    = IW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] GUESS_INIT = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IW-1:0]     idx;
    logic [WIDTH-1:0]  trial;
    logic              busy_next;
    logic              done_next;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: equality or the last bit ends the search.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = TEST;
            TEST:    if (I || (idx == '0)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode on the next state so busy/done come straight from flops.
    always_comb begin
        busy_next = (state_next == TEST);
        done_next = (state_next == DONE);
    end

    // Refined guess: current bit follows M, next lower bit becomes the new trial bit.
    always_comb begin
        trial      = guess;
        trial[idx] = M;
        if (idx != '0) begin
            trial[idx - IW'(1)] = 1'b1;
        end
    end

    // Datapath registers: trial value, bit index, step count and result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            guess  <= '0;
            result <= '0;
            steps  <= '0;
            idx    <= IDX_TOP;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            busy <= busy_next;
            done <= done_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        guess <= GUESS_INIT;
                        idx   <= IDX_TOP;
                        steps <= '0;
                    end
                end
                TEST: begin
                    steps <= steps + SW'(1);
                    if (I) begin
                        // Equality wins even if M is (illegally) also set.
                        result <= guess;
                        guess  <= '0;
                    end else if (idx == '0) begin
                        // Last bit: trial already carries bit0 = M.
                        result <= trial;
                        guess  <= '0;
                    end else begin
                        guess <= trial;
                        idx   <= idx - IW'(1);
                    end
                end
                DONE: begin
                    guess <= '0;
                    idx   <= IDX_TOP;
                end
                default: begin
                    guess <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/busca_aproximacao.md
Name: busca_aproximacao

Overview:
- Successive-approximation search engine. It is the initiator side of the 8-bit magnitude comparator interface (a, b in; M = a>b, I = a==b out).
- Drives a trial value onto comparator input b, where a is an unknown target, and reads back M/I.
- Resolves the target MSB-first in at most WIDTH cycles, terminating early on equality.
- Sits beside the combinational comparator tree; pairs with it to recover a hidden value.

Parameters:
- WIDTH, 8, operand width; even, >= 2; must equal the comparator width.
- SW, 4, width of step counter; must satisfy 2^SW > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request a new search; accepted only in IDLE.
- M  input  1  comparator greater flag (target > guess); combinational from guess.
- I  input  1  comparator equal flag (target == guess); combinational from guess.
- guess  output  WIDTH  registered trial value, wired to comparator b.
- result  output  WIDTH  resolved target; held until the next accepted start.
- steps  output  SW  number of TEST cycles used by the last/current search.
- busy  output  1  high while in TEST.
- done  output  1  one-cycle pulse when result is valid.

Behaviour:
- Reset, asynchronous, at any time including mid-search:
  - state=IDLE, guess=0, result=0, steps=0, busy=0, done=0, bit index=WIDTH-1.
- States: IDLE, TEST, DONE.
- IDLE:
  - start=1 -> TEST; guess=1 followed by WIDTH-1 zeros (0x80 for WIDTH=8); idx=WIDTH-1; steps=0.
  - start=0 -> stay in IDLE.
- TEST, one comparison per clock; M/I are sampled the same cycle guess is presented:
  - steps increments every TEST cycle.
  - I=1 -> result=guess, then DONE. Takes priority over M.
  - Else, if idx==0: result = guess with bit0 = M (keep if M, clear if not), then DONE.
  - Else: guess[idx] = M (keep if M=1, clear if 0); guess[idx-1]=1; idx decrements; stay in TEST.
- DONE, exactly one cycle:
  - done=1, busy=0, guess=0.
  - Next state IDLE. start is ignored in DONE.
- busy=1 exactly while in TEST. start while busy or in DONE is ignored; the search is not restarted.
- Latency:
  - The start edge enters TEST.
  - The done pulse appears steps+1 cycles after the start edge.
  - steps is in 1..WIDTH.
- Boundary cases:
  - target=0: never equal; all bits cleared; steps=WIDTH; result=0.
  - target=all-ones: I on the final step; steps=WIDTH.
  - M=1 and I=1 together (illegal from a correct comparator): I wins.
  - M=1 at idx==0 without I (inconsistent comparator): bit0 kept; no error flagged.
- All outputs are registered. There is no combinational path from M/I to any output.

Test Plan:
- Target 0x80, pulse start -> guess=0x80 for 1 TEST cycle; I=1; done 2 cycles after start; result=0x80, steps=1.
- Target 0x5A -> guess sequence 0x80,0x40,0x60,0x50,0x58,0x5C,0x5A; I on 7th; result=0x5A, steps=7.
- Target 0x00 -> guesses 0x80,0x40,...,0x01, no I; result=0x00, steps=8, done 9 cycles after start.
- Target 0xFF -> guesses 0x80,0xC0,...,0xFF; I on step 8; result=0xFF, steps=8.
- Assert start during TEST (target 0x33) -> ignored; result=0x33; exactly one done pulse.
- Assert rst on 3rd TEST cycle -> all outputs 0 immediately, state IDLE; new start to target 0x01 completes with result=0x01, steps=8.
